load_store_unit: RTL and testbench

- Data-memory access stage directly downstream of the ALU in the RISC-V core.
- Takes the ALU result as the effective address of a load or store. Drives a simple req/ack data bus with byte enables, and returns aligned, sign- or zero-extended load data to writeback.
- Stalls the single-cycle core while a bus access is outstanding, and reports misaligned accesses, illegal widths and bus timeouts.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/load_data_formatter.sv | 32 +++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: access widths, FSM states, fault causes.
package riscv_pkg;

   // funct3 access width/sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // LSU state encodings
   typedef enum logic [1:0] {
      LsuIdle = 2'd0,
      LsuReq  = 2'd1,
      LsuResp = 2'd2,
      LsuErr  = 2'd3
   } lsu_state_e;

   // Fault cause codes
   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   // Classify an access before it reaches the bus; illegal width wins over misalignment.
   function automatic logic [1:0] lsu_check(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
      logic illegal;
      logic misalign;
      if (is_store) begin
         illegal = !(funct3 inside {F3_B, F3_H, F3_W});
      end else begin
         illegal = funct3 inside {3'b011, 3'b110, 3'b111};
      end
      case (funct3)
         F3_H, F3_HU: misalign = addr_lo[0];
         F3_W:        misalign = |addr_lo;
         default:     misalign = 1'b0;
      endcase
      if (illegal) begin
         return CAUSE_ILLEGAL;
      end else if (misalign) begin
         return CAUSE_MISALIGN;
      end
      return CAUSE_NONE;
   endfunction

endpackage

// File: rtl/load_data_formatter.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_data_formatter
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection followed by extension according to the access type
   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result_o = {24'h0, byte_sel};
         F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result_o = {16'h0, half_sel};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: drives a req/ack bus, formats load data, stalls the core
// while an access is outstanding and reports misaligned, illegal and timed-out accesses.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_W           = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] load_data_o,
   output logic        fault_o,
   output logic [1:0]  fault_cause_o
);

   localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e      state_q;
   logic [TO_W-1:0] cnt_q;
   logic [1:0]      addr_lo_q;
   logic [2:0]      funct3_q;

   logic        trigger;
   logic [1:0]  check_cause;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [31:0] fmt_data;

   assign trigger = mem_read_i | mem_write_i;

   // Stall is combinational so the core advances exactly on the done_o cycle
   assign stall_o = ((state_q == LsuIdle) && trigger) || (state_q == LsuReq);

   // Fault classification and store lane steering for the access presented in IDLE
   always_comb begin
      check_cause = lsu_check(mem_write_i, funct3_i, addr_i[1:0]);
      be_d        = 4'b1111;
      wdata_d     = 32'h0;
      if (mem_write_i) begin
         case (funct3_i)
            F3_B: begin
               be_d    = 4'b0001 << addr_i[1:0];
               wdata_d = {4{store_data_i[7:0]}};
            end
            F3_H: begin
               be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
               wdata_d = {2{store_data_i[15:0]}};
            end
            default: begin
               be_d    = 4'b1111;
               wdata_d = store_data_i;
            end
         endcase
      end
   end

   load_data_formatter u_formatter (
      .rdata_i   (bus_rdata_i),
      .addr_lo_i (addr_lo_q),
      .funct3_i  (funct3_q),
      .result_o  (fmt_data)
   );

   // Access FSM with registered bus and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= LsuIdle;
         cnt_q         <= '0;
         addr_lo_q     <= 2'b00;
         funct3_q      <= 3'b000;
         bus_req_o     <= 1'b0;
         bus_we_o      <= 1'b0;
         bus_addr_o    <= 32'h0;
         bus_be_o      <= 4'h0;
         bus_wdata_o   <= 32'h0;
         done_o        <= 1'b0;
         fault_o       <= 1'b0;
         fault_cause_o <= CAUSE_NONE;
         load_data_o   <= 32'h0;
      end else begin
         done_o  <= 1'b0;
         fault_o <= 1'b0;
         case (state_q)
            LsuIdle: begin
               if (trigger) begin
                  if (check_cause != CAUSE_NONE) begin
                     state_q       <= LsuErr;
                     done_o        <= 1'b1;
                     fault_o       <= 1'b1;
                     fault_cause_o <= check_cause;
                  end else begin
                     state_q     <= LsuReq;
                     cnt_q       <= '0;
                     bus_req_o   <= 1'b1;
                     bus_we_o    <= mem_write_i;
                     bus_addr_o  <= {addr_i[31:2], 2'b00};
                     bus_be_o    <= be_d;
                     bus_wdata_o <= wdata_d;
                     addr_lo_q   <= addr_i[1:0];
                     funct3_q    <= funct3_i;
                  end
               end
            end
            LsuReq: begin
               if (bus_ack_i) begin
                  state_q   <= LsuResp;
                  bus_req_o <= 1'b0;
                  done_o    <= 1'b1;
                  if (!bus_we_o) begin
                     load_data_o <= fmt_data;
                  end
               end else if (cnt_q == CntLast) begin
                  state_q       <= LsuErr;
                  bus_req_o     <= 1'b0;
                  done_o        <= 1'b1;
                  fault_o       <= 1'b1;
                  fault_cause_o <= CAUSE_TIMEOUT;
                  load_data_o   <= 32'h0;
               end else begin
                  cnt_q <= cnt_q + TO_W'(1);
               end
            end
            LsuResp: begin
               // Triggers still belong to the finishing instruction
               state_q <= LsuIdle;
            end
            default: begin
               state_q       <= LsuIdle;
               fault_cause_o <= CAUSE_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions are queued when an access is
// driven and compared when done_o pulses.
module tb_load_store_unit;
   import riscv_pkg::*;

   localparam int unsigned TO = 8;

   typedef struct packed {
      logic        fault;
      logic [1:0]  cause;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_i, mem_write_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, store_data_i;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        stall_o, done_o, fault_o;
   logic [31:0] load_data_o;
   logic [1:0]  fault_cause_o;

   logic [31:0] ref_rdata;
   logic [1:0]  ref_lo;
   logic [2:0]  ref_f3;
   logic [31:0] ref_data;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_ld  = 32'h0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .mem_read_i    (mem_read_i),
      .mem_write_i   (mem_write_i),
      .funct3_i      (funct3_i),
      .addr_i        (addr_i),
      .store_data_i  (store_data_i),
      .bus_req_o     (bus_req_o),
      .bus_we_o      (bus_we_o),
      .bus_addr_o    (bus_addr_o),
      .bus_be_o      (bus_be_o),
      .bus_wdata_o   (bus_wdata_o),
      .bus_ack_i     (bus_ack_i),
      .bus_rdata_i   (bus_rdata_i),
      .stall_o       (stall_o),
      .done_o        (done_o),
      .load_data_o   (load_data_o),
      .fault_o       (fault_o),
      .fault_cause_o (fault_cause_o)
   );

   load_data_formatter ref_fmt (
      .rdata_i   (ref_rdata),
      .addr_lo_i (ref_lo),
      .funct3_i  (ref_f3),
      .result_o  (ref_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one access from posedge+1 until done_o, then checks the unit is idle again.
   // ack_wait: REQ cycles without ack before acking (negative = never ack).
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input int ack_wait,
                            input logic exp_fault, input logic [1:0] exp_cause,
                            input logic [31:0] exp_data, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata,
                            output int stall_cnt, output int req_cnt, output int done_cyc);
      exp_t e;
      logic first;
      stall_cnt = 0;
      req_cnt   = 0;
      done_cyc  = 0;
      first     = 1'b1;
      e.fault   = exp_fault;
      e.cause   = exp_cause;
      e.data    = exp_data;
      sb_q.push_back(e);
      mem_read_i   = rd;
      mem_write_i  = wr;
      funct3_i     = f3;
      addr_i       = addr;
      store_data_i = sdata;
      bus_rdata_i  = rdata;
      for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
         bus_ack_i = bus_req_o && (ack_wait >= 0) && (req_cnt == ack_wait);
         @(negedge clk);
         if (stall_o) stall_cnt++;
         if (bus_req_o) begin
            if (first) begin
               check("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
               check("bus_be", {28'h0, bus_be_o}, {28'h0, exp_be});
               check("bus_we", {31'h0, bus_we_o}, {31'h0, wr});
               if (wr) check("bus_wdata", bus_wdata_o, exp_wdata);
               first = 1'b0;
            end
            req_cnt++;
         end
         if (done_o) begin
            done_cyc = cyc;
            if (sb_q.size() == 0) begin
               check("sb_nonempty", 32'd0, 32'd1);
            end else begin
               e = sb_q.pop_front();
               check("fault", {31'h0, fault_o}, {31'h0, e.fault});
               check("cause", {30'h0, fault_cause_o}, {30'h0, e.cause});
               check("load_data", load_data_o, e.data);
            end
         end
         @(posedge clk);
         #1;
      end
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      bus_ack_i   = 1'b0;
      if (done_cyc == 0) check("done_seen", 32'd0, 32'd1);
      @(negedge clk);
      check("after_req", {31'h0, bus_req_o}, 32'd0);
      check("after_done", {31'h0, done_o}, 32'd0);
      check("after_cause", {30'h0, fault_cause_o}, {30'h0, CAUSE_NONE});
      @(posedge clk);
      #1;
   endtask

   initial begin
      int st, rq, dc;
      logic [2:0] f3_tab [5];
      logic [2:0] f3;
      logic [1:0] lo;
      int aw;
      f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
      reset = 1'b1;
      mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
      addr_i = 32'h0; store_data_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
      ref_rdata = 32'h0; ref_lo = 2'b00; ref_f3 = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_req", {31'h0, bus_req_o}, 32'd0);
      check("rst_we", {31'h0, bus_we_o}, 32'd0);
      check("rst_addr", bus_addr_o, 32'h0);
      check("rst_be", {28'h0, bus_be_o}, 32'h0);
      check("rst_wdata", bus_wdata_o, 32'h0);
      check("rst_done", {31'h0, done_o}, 32'd0);
      check("rst_fault", {31'h0, fault_o}, 32'd0);
      check("rst_cause", {30'h0, fault_cause_o}, 32'd0);
      check("rst_ld", load_data_o, 32'h0);
      check("rst_stall", {31'h0, stall_o}, 32'd0);
      @(posedge clk);
      #1;

      // LB at byte 3, immediate ack
      do_access(1, 0, F3_B, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
                0, CAUSE_NONE, 32'hFFFF_FF80, 4'b1111, 32'h0, st, rq, dc);
      last_ld = 32'hFFFF_FF80;
      check("lb_stall", st, 2); check("lb_req", rq, 1); check("lb_done", dc, 3);

      // SH upper half, ack after 4 wait cycles
      do_access(0, 1, F3_H, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 4,
                0, CAUSE_NONE, last_ld, 4'b1100, 32'hABCD_ABCD, st, rq, dc);
      check("sh_req", rq, 5); check("sh_stall", st, 6); check("sh_done", dc, 7);

      // SB at byte 1 and SW
      do_access(0, 1, F3_B, 32'h0000_0041, 32'h1122_3344, 32'h0, 1,
                0, CAUSE_NONE, last_ld, 4'b0010, 32'h4444_4444, st, rq, dc);
      check("sb_req", rq, 2);
      do_access(0, 1, F3_W, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 0,
                0, CAUSE_NONE, last_ld, 4'b1111, 32'hDEAD_BEEF, st, rq, dc);

      // Directed load formats on 0x80FF_1234
      do_access(1, 0, F3_BU, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0,
                0, CAUSE_NONE, 32'h0000_00FF, 4'b1111, 32'h0, st, rq, dc);
      do_access(1, 0, F3_H, 32'h0000_0102, 32'h0, 32'h80FF_1234, 2,
                0, CAUSE_NONE, 32'hFFFF_80FF, 4'b1111, 32'h0, st, rq, dc);
      do_access(1, 0, F3_HU, 32'h0000_0100, 32'h0, 32'h80FF_1234, 0,
                0, CAUSE_NONE, 32'h0000_1234, 4'b1111, 32'h0, st, rq, dc);
      do_access(1, 0, F3_B, 32'h0000_0101, 32'h0, 32'h80FF_1234, 0,
                0, CAUSE_NONE, 32'h0000_0012, 4'b1111, 32'h0, st, rq, dc);
      do_access(1, 0, F3_W, 32'h0000_0100, 32'h0, 32'h80FF_1234, 0,
                0, CAUSE_NONE, 32'h80FF_1234, 4'b1111, 32'h0, st, rq, dc);
      last_ld = 32'h80FF_1234;

      // Faults detected in IDLE: no bus activity, load data held
      do_access(1, 0, F3_W, 32'h0000_0006, 32'h0, 32'h0, 0,
                1, CAUSE_MISALIGN, last_ld, 4'b0, 32'h0, st, rq, dc);
      check("lw_mis_req", rq, 0); check("lw_mis_done", dc, 2); check("lw_mis_stall", st, 1);
      do_access(0, 1, 3'b100, 32'h0000_0010, 32'h0, 32'h0, 0,
                1, CAUSE_ILLEGAL, last_ld, 4'b0, 32'h0, st, rq, dc);
      check("st_ill_req", rq, 0);
      do_access(0, 1, F3_H, 32'h0000_0011, 32'h0, 32'h0, 0,
                1, CAUSE_MISALIGN, last_ld, 4'b0, 32'h0, st, rq, dc);
      do_access(1, 0, 3'b111, 32'h0000_0011, 32'h0, 32'h0, 0,
                1, CAUSE_ILLEGAL, last_ld, 4'b0, 32'h0, st, rq, dc);
      // Read and write together is a write, so BU width is illegal
      do_access(1, 1, F3_BU, 32'h0000_0010, 32'h0, 32'h0, 0,
                1, CAUSE_ILLEGAL, last_ld, 4'b0, 32'h0, st, rq, dc);

      // Timeout on LHU
      do_access(1, 0, F3_HU, 32'h0000_0010, 32'h0, 32'h0, -1,
                1, CAUSE_TIMEOUT, 32'h0, 4'b1111, 32'h0, st, rq, dc);
      check("to_req", rq, TO); check("to_stall", st, TO + 1); check("to_done", dc, TO + 2);

      // Random loads against the reference formatter
      for (int i = 0; i < 6; i++) begin
         f3 = f3_tab[$urandom_range(0, 4)];
         lo = 2'($urandom_range(0, 3));
         if (f3 == F3_H || f3 == F3_HU) lo[0] = 1'b0;
         if (f3 == F3_W) lo = 2'b00;
         ref_rdata = $urandom;
         ref_lo    = lo;
         ref_f3    = f3;
         aw        = $urandom_range(0, 3);
         #1;
         do_access(1, 0, f3, {20'h00003, 10'($urandom), lo}, 32'h0, ref_rdata, aw,
                   0, CAUSE_NONE, ref_data, 4'b1111, 32'h0, st, rq, dc);
         check("rnd_stall", st, aw + 2);
         last_ld = ref_data;
      end

      // Reset in the 2nd REQ cycle, late ack must be ignored
      do_access(1, 0, F3_W, 32'h0000_0100, 32'h0, 32'h80FF_1234, 0,
                0, CAUSE_NONE, 32'h80FF_1234, 4'b1111, 32'h0, st, rq, dc);
      mem_read_i = 1'b1; funct3_i = F3_W; addr_i = 32'h0000_0020;
      bus_rdata_i = 32'h1234_5678;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst2_in_req", {31'h0, bus_req_o}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0; mem_read_i = 1'b0; bus_ack_i = 1'b1;
      @(negedge clk);
      check("rst2_req", {31'h0, bus_req_o}, 32'd0);
      check("rst2_done", {31'h0, done_o}, 32'd0);
      check("rst2_stall", {31'h0, stall_o}, 32'd0);
      check("rst2_ld", load_data_o, 32'h0);
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      @(negedge clk);
      check("rst2_done2", {31'h0, done_o}, 32'd0);
      check("rst2_ld2", load_data_o, 32'h0);
      check("sb_drained", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
